// File: rtl/encoder8_serial_if.sv
// Handshake bundle for encoder8_serial: a line-word input channel (in_*/Z),
// an index output channel (out_*/A/out_last) and the zero_drop side pulse.
// When ENC_POPCNT_EN is defined the bundle also carries the cnt signal.
interface encoder8_serial_if #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) ();
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  Z;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] A;
    logic          out_last;
    logic          zero_drop;
`ifdef ENC_POPCNT_EN
    logic [AW:0]   cnt;
`endif

    // Producer of words and consumer of indices (e.g. a testbench or upstream arbiter).
    modport master (
        output in_valid, Z, out_ready,
        input  in_ready, out_valid, A, out_last, zero_drop
`ifdef ENC_POPCNT_EN
        , input cnt
`endif
    );

    // The encoder itself.
    modport slave (
        input  in_valid, Z, out_ready,
        output in_ready, out_valid, A, out_last, zero_drop
`ifdef ENC_POPCNT_EN
        , output cnt
`endif
    );
endinterface

// File: rtl/encoder8_serial.sv
// encoder8_serial: sequential 8-to-3 encoder.
// Captures a line word Z, then emits the index of every set line, lowest
// first, one per out_valid/out_ready handshake; out_last flags the final one.
// An all-zero word is accepted and discarded with a one-cycle zero_drop pulse.
// Optional feature macro: ENC_POPCNT_EN adds a remaining-index counter (cnt).
// All outputs decode from registered state (and rst), never from Z.
module encoder8_serial #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic clk,
    input  logic rst,
    encoder8_serial_if.slave bus
);
    typedef enum logic [0:0] {IDLE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pend_q;
    logic          zero_drop_q;

    logic [AW-1:0] low_idx;
    logic          one_left;
    logic [N-1:0]  clr_mask;
    logic          in_rdy;
    logic          out_vld;
    logic          capture;
    logic          zero_word;
    logic          hs;

    // Lowest pending line index; scanning high-to-low lets the lowest hit win.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) low_idx = AW'(i);
        end
    end

    // Exactly one bit pending: the index now on A is the last of the word.
    always_comb begin
        one_left = (pend_q != '0) && ((pend_q & (pend_q - N'(1))) == '0);
        clr_mask = N'(1) << low_idx;
    end

    // Handshake qualifiers; rst forces both channels quiet immediately.
    always_comb begin
        in_rdy    = (state_q == IDLE) && !rst;
        out_vld   = (state_q == DRAIN) && !rst;
        zero_word = (bus.Z == '0);
        capture   = in_rdy && bus.in_valid && !zero_word;
        hs        = out_vld && bus.out_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: leave IDLE on a non-zero capture, return after the last index.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = DRAIN;
            DRAIN:   if (hs && one_left) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pending lines: loaded on capture, one bit retired per handshake.
    always_ff @(posedge clk) begin
        if (rst)          pend_q <= '0;
        else if (capture) pend_q <= bus.Z;
        else if (hs)      pend_q <= pend_q & ~clr_mask;
    end

    // zero_drop fires the cycle after an all-zero word is accepted.
    always_ff @(posedge clk) begin
        if (rst) zero_drop_q <= 1'b0;
        else     zero_drop_q <= in_rdy && bus.in_valid && zero_word;
    end

`ifdef ENC_POPCNT_EN
    logic [AW:0] cnt_q;
    logic [AW:0] z_pop;

    // Population count of the incoming word.
    always_comb begin
        z_pop = '0;
        for (int i = 0; i < N; i++) z_pop = z_pop + (AW + 1)'(bus.Z[i]);
    end

    // Remaining-index counter; a zero word loads 0, so IDLE always reads 0.
    always_ff @(posedge clk) begin
        if (rst)                           cnt_q <= '0;
        else if (in_rdy && bus.in_valid)   cnt_q <= z_pop;
        else if (hs)                       cnt_q <= cnt_q - (AW + 1)'(1);
    end

    assign bus.cnt = cnt_q;
`endif

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.A         = out_vld ? low_idx : '0;
    assign bus.out_last  = out_vld && one_left;
    assign bus.zero_drop = zero_drop_q;
endmodule

// File: tb/tb_encoder8_serial.sv
// Testbench for encoder8_serial: directed scenarios plus randomized words
// checked against a queue-of-indices reference model.
module tb_encoder8_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    encoder8_serial_if #(.N(8), .AW(3)) bus ();

    encoder8_serial #(.N(8), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: ascending list of set-bit positions of the word.
    task automatic load_model(input logic [7:0] z);
        exp_q.delete();
        for (int i = 0; i < 8; i++) if (z[i]) exp_q.push_back(i);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b0; bus.Z = '0; bus.out_ready = 1'b0;
        tick(); tick();
        total++;
        if ({bus.in_ready, bus.out_valid, bus.A, bus.out_last, bus.zero_drop} !== 7'b0) begin
            bad++; $display("FAIL reset_outputs got=%b want=0000000",
                {bus.in_ready, bus.out_valid, bus.A, bus.out_last, bus.zero_drop});
        end
        rst = 1'b0; #1;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", bus.in_ready); end
`ifdef ENC_POPCNT_EN
        total++;
        if (bus.cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.cnt); end
`endif
    endtask

    // T1: 0xA4 with out_ready=1 gives 2,5,7 back to back.
    task automatic test_basic();
        bus.in_valid = 1'b1; bus.Z = 8'hA4; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.Z = '0;
        load_model(8'hA4);
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({bus.out_valid, bus.A, bus.out_last, bus.in_ready} !==
                {1'b1, 3'(exp_q[k]), (k == 2), 1'b0}) begin
                bad++; $display("FAIL basic_idx%0d got v=%b A=%0d last=%b ir=%b want A=%0d",
                    k, bus.out_valid, bus.A, bus.out_last, bus.in_ready, exp_q[k]);
            end
            tick();
        end
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            bad++; $display("FAIL basic_return_idle got ir=%b v=%b want ir=1 v=0", bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b0;
    endtask

    // T2: back-pressure holds A=0 stable, then 0 and 7(last).
    task automatic test_backpressure();
        bus.in_valid = 1'b1; bus.Z = 8'h81; bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({bus.out_valid, bus.A, bus.out_last} !== 5'b1_000_0) begin
                bad++; $display("FAIL bp_hold%0d got v=%b A=%0d last=%b want v=1 A=0 last=0",
                    k, bus.out_valid, bus.A, bus.out_last);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        total++;
        if ({bus.out_valid, bus.A, bus.out_last} !== 5'b1_000_0) begin
            bad++; $display("FAIL bp_first got A=%0d last=%b want A=0 last=0", bus.A, bus.out_last);
        end
        tick();
        total++;
        if ({bus.out_valid, bus.A, bus.out_last} !== 5'b1_111_1) begin
            bad++; $display("FAIL bp_second got v=%b A=%0d last=%b want v=1 A=7 last=1",
                bus.out_valid, bus.A, bus.out_last);
        end
        tick();
        bus.out_ready = 1'b0;
    endtask

    // T3: zero word is swallowed with a single-cycle zero_drop.
    task automatic test_zero();
        bus.in_valid = 1'b1; bus.Z = 8'h00;
        tick();
        bus.in_valid = 1'b0;
        total++;
        if ({bus.zero_drop, bus.out_valid, bus.in_ready} !== 3'b101) begin
            bad++; $display("FAIL zero_pulse got zd=%b v=%b ir=%b want zd=1 v=0 ir=1",
                bus.zero_drop, bus.out_valid, bus.in_ready);
        end
        tick();
        total++;
        if ({bus.zero_drop, bus.out_valid} !== 2'b00) begin
            bad++; $display("FAIL zero_pulse_end got zd=%b v=%b want 0 0", bus.zero_drop, bus.out_valid);
        end
    endtask

    // T4: words offered during DRAIN are ignored until IDLE.
    task automatic test_ignore();
        bus.in_valid = 1'b1; bus.Z = 8'h03; bus.out_ready = 1'b1;
        tick();
        bus.Z = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({bus.out_valid, bus.A, bus.out_last, bus.in_ready} !== {1'b1, 3'(k), (k == 1), 1'b0}) begin
                bad++; $display("FAIL ignore_idx%0d got v=%b A=%0d last=%b ir=%b want A=%0d",
                    k, bus.out_valid, bus.A, bus.out_last, bus.in_ready, k);
            end
            tick();
        end
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            bad++; $display("FAIL ignore_bubble got ir=%b v=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        total++;
        if ({bus.out_valid, bus.A} !== 4'b1_000) begin
            bad++; $display("FAIL ignore_late_capture got v=%b A=%0d want v=1 A=0", bus.out_valid, bus.A);
        end
        for (int k = 0; k < 8; k++) tick();
        bus.out_ready = 1'b0;
    endtask

    // T5: reset mid-drain discards remaining bits.
    task automatic test_reset_mid();
        bus.in_valid = 1'b1; bus.Z = 8'hF0; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        total++;
        if ({bus.out_valid, bus.A} !== 4'b1_100) begin
            bad++; $display("FAIL rstmid_first got v=%b A=%0d want v=1 A=4", bus.out_valid, bus.A);
        end
        tick();
        rst = 1'b1; bus.out_ready = 1'b0;
        tick();
        total++;
        if ({bus.out_valid, bus.in_ready, bus.A, bus.out_last} !== 6'b0) begin
            bad++; $display("FAIL rstmid_quiet got v=%b ir=%b A=%0d last=%b want all 0",
                bus.out_valid, bus.in_ready, bus.A, bus.out_last);
        end
        rst = 1'b0; #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                bad++; $display("FAIL rstmid_stale%0d got ir=%b v=%b A=%0d want ir=1 v=0",
                    k, bus.in_ready, bus.out_valid, bus.A);
            end
            tick();
        end
    endtask

    // T6: full word; decoding every A rebuilds Z, cnt counts 8..1.
    task automatic test_decode();
        logic [7:0] rebuilt;
        rebuilt = '0;
        bus.in_valid = 1'b1; bus.Z = 8'hFF; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.out_valid) rebuilt = rebuilt | (8'd1 << bus.A);
`ifdef ENC_POPCNT_EN
            total++;
            if (bus.cnt !== 4'(8 - k)) begin bad++; $display("FAIL decode_cnt%0d got=%0d want=%0d", k, bus.cnt, 8 - k); end
`endif
            tick();
        end
        total++;
        if (rebuilt !== 8'hFF) begin bad++; $display("FAIL decode_rebuild got=%h want=ff", rebuilt); end
        bus.out_ready = 1'b0;
    endtask

    // Random words, random back-pressure, junk offered during DRAIN.
    task automatic test_random();
        logic [7:0] z;
        int pct, guard;
        bit rdy;
        for (int w = 0; w < 60; w++) begin
            z = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            pct = $urandom_range(25, 100);
            load_model(z);
            total++;
            if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rnd_idle%0d got ir=%b want 1", w, bus.in_ready); end
            bus.in_valid = 1'b1; bus.Z = z; bus.out_ready = 1'b0;
            tick();
            if (exp_q.size() == 0) begin
                bus.in_valid = 1'b0;
                total++;
                if ({bus.zero_drop, bus.out_valid} !== 2'b10) begin
                    bad++; $display("FAIL rnd_zero%0d got zd=%b v=%b want 1 0", w, bus.zero_drop, bus.out_valid);
                end
                tick();
                continue;
            end
            guard = 0;
            while (exp_q.size() > 0 && guard < 200) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.Z = 8'($urandom);
                rdy = ($urandom_range(1, 100) <= pct);
                bus.out_ready = rdy;
                total++;
                if ({bus.out_valid, bus.A, bus.out_last, bus.in_ready, bus.zero_drop} !==
                    {1'b1, 3'(exp_q[0]), (exp_q.size() == 1), 1'b0, 1'b0}) begin
                    bad++; $display("FAIL rnd_idx w%0d z=%h got v=%b A=%0d last=%b ir=%b zd=%b want A=%0d last=%b",
                        w, z, bus.out_valid, bus.A, bus.out_last, bus.in_ready, bus.zero_drop,
                        exp_q[0], (exp_q.size() == 1));
                end
`ifdef ENC_POPCNT_EN
                total++;
                if (bus.cnt !== 4'(exp_q.size())) begin
                    bad++; $display("FAIL rnd_cnt w%0d got=%0d want=%0d", w, bus.cnt, exp_q.size());
                end
`endif
                tick();
                if (rdy) void'(exp_q.pop_front());
                guard++;
            end
            if (guard >= 200) begin
                total++; bad++; $display("FAIL rnd_timeout w%0d remaining=%0d want 0", w, exp_q.size());
            end
            bus.in_valid = 1'b0; bus.out_ready = 1'b0;
            total++;
            if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                bad++; $display("FAIL rnd_done w%0d got ir=%b v=%b want 1 0", w, bus.in_ready, bus.out_valid);
            end
`ifdef ENC_POPCNT_EN
            total++;
            if (bus.cnt !== 4'd0) begin bad++; $display("FAIL rnd_cnt_idle w%0d got=%0d want=0", w, bus.cnt); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_ignore();
        test_reset_mid();
        test_decode();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
